// File: rtl/nmr_dsp_pkg.sv
// Shared NMR DSP definitions: sample format defaults and the capture state encoding.
package nmr_dsp_pkg;

    localparam int SAMP_DEF = 4;
    localparam int BITS_DEF = 16;
    localparam int IQ_W_DEF = 2 * SAMP_DEF * BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } cap_state_t;

    function automatic int iq_width(input int samp, input int bits);
        return 2 * samp * bits;
    endfunction

endpackage

// File: rtl/iq_capture_buffer_if.sv
// Filtered I/Q input stream plus the record read stream; master is the capture buffer side.
interface iq_capture_buffer_if
    import nmr_dsp_pkg::*;
#(
    parameter int SAMP = SAMP_DEF,
    parameter int BITS = BITS_DEF
);
    logic [SAMP*BITS-1:0]   data_in_i;
    logic [SAMP*BITS-1:0]   data_in_q;
    logic                   data_valid;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [2*SAMP*BITS-1:0] rd_data;
    logic                   rd_last;

    modport master (
        input  data_in_i, data_in_q, data_valid, rd_ready,
        output rd_valid, rd_data, rd_last
    );

    modport slave (
        output data_in_i, data_in_q, data_valid, rd_ready,
        input  rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/iq_capture_ram.sv
// Simple dual-port record RAM, one write port and one registered read port (block RAM).
// Latency: write lands at the clock edge; read data valid one cycle after re; no backpressure.
module iq_capture_ram #(
    parameter  int DEPTH = 1024,
    parameter  int W     = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/iq_capture_buffer.sv
// Armed, decimating I/Q record capture into RAM, drained over a valid/ready read port.
// Latency: rd_valid 2 cycles after READOUT entry; backpressure: rd_ready stalls via output reg + 1-entry skid.
module iq_capture_buffer
    import nmr_dsp_pkg::*;
#(
    parameter  int SAMP  = SAMP_DEF,
    parameter  int BITS  = BITS_DEF,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int W     = iq_width(SAMP, BITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    iq_capture_buffer_if.master        bus,
    input  logic                       arm,
    input  logic [7:0]                 decim,
    input  logic [AW:0]                capture_len,
    output logic                       busy,
    output logic                       capture_done
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    cap_state_t    state, state_nxt;
    logic          in_idle, in_cap, in_rd;

    logic [7:0]    decim_r, dcnt;
    logic [AW-1:0] last_idx_r, len_idx;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          rd_issued_all;

    logic          accept, wr_last, issue, pop, room;
    logic [1:0]    occ;

    logic          ram_vld, ram_last;
    logic [W-1:0]  ram_q;
    logic          skid_vld, skid_last;
    logic [W-1:0]  skid_dat;
    logic          out_vld, out_last;
    logic [W-1:0]  out_dat;

    // Zero or oversize length means a full-depth record; held as the index of the final word.
    always_comb begin
        len_idx = '1;
        if (capture_len != '0 && capture_len <= DEPTH_W) begin
            len_idx = AW'(capture_len - ONE_W);
        end
    end

    assign accept  = in_cap && bus.data_valid && (dcnt == 8'd0);
    assign wr_last = accept && (wr_addr == last_idx_r);

    // Words owned by the read pipeline: output reg, skid and the RAM read in flight.
    assign occ   = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld};
    assign pop   = out_vld && bus.rd_ready;
    assign room  = (occ < 2'd2) || ((occ == 2'd2) && pop);
    assign issue = in_rd && !rd_issued_all && room;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arm)              state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (wr_last)          state_nxt = ST_READOUT;
            ST_READOUT: if (pop && out_last)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_idle = (state == ST_IDLE);
        in_cap  = (state == ST_CAPTURE);
        in_rd   = (state == ST_READOUT);
        busy    = !in_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_r       <= '0;
            last_idx_r    <= '0;
            dcnt          <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            rd_issued_all <= 1'b0;
            capture_done  <= 1'b0;
            ram_vld       <= 1'b0;
            ram_last      <= 1'b0;
        end else begin
            capture_done <= wr_last;
            ram_vld      <= issue;
            ram_last     <= issue && (rd_addr == last_idx_r);
            if (in_idle && arm) begin
                decim_r       <= decim;
                last_idx_r    <= len_idx;
                dcnt          <= '0;
                wr_addr       <= '0;
                rd_addr       <= '0;
                rd_issued_all <= 1'b0;
            end
            if (in_cap && bus.data_valid) begin
                dcnt <= (dcnt == decim_r) ? 8'd0 : dcnt + 8'd1;
            end
            if (accept) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (issue) begin
                rd_addr <= rd_addr + AW'(1);
                if (rd_addr == last_idx_r) begin
                    rd_issued_all <= 1'b1;
                end
            end
        end
    end

    // Output register refills from the skid first so word order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_dat   <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_dat  <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_vld   <= 1'b1;
                out_dat   <= skid_dat;
                out_last  <= skid_last;
                skid_vld  <= ram_vld;
                skid_last <= ram_vld && ram_last;
                if (ram_vld) begin
                    skid_dat <= ram_q;
                end
            end else begin
                out_vld  <= ram_vld;
                out_last <= ram_vld && ram_last;
                if (ram_vld) begin
                    out_dat <= ram_q;
                end
            end
        end else if (ram_vld) begin
            skid_vld  <= 1'b1;
            skid_dat  <= ram_q;
            skid_last <= ram_last;
        end
    end

    assign bus.rd_valid = out_vld;
    assign bus.rd_data  = out_dat;
    assign bus.rd_last  = out_last;

    iq_capture_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_addr),
        .wdata ({bus.data_in_q, bus.data_in_i}),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Randomized scoreboard bench for iq_capture_buffer with a small-depth instance.
module tb_iq_capture_buffer;

    localparam int SAMP  = 4;
    localparam int BITS  = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int W     = 2 * SAMP * BITS;

    typedef struct {
        logic [W-1:0] dat;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic [7:0]    decim;
    logic [AW:0]   capture_len;
    logic          busy;
    logic          capture_done;

    iq_capture_buffer_if #(.SAMP(SAMP), .BITS(BITS)) bus ();

    iq_capture_buffer #(
        .SAMP  (SAMP),
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .arm          (arm),
        .decim        (decim),
        .capture_len  (capture_len),
        .busy         (busy),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           done_cnt = 0;
    int           ready_mode = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    task automatic check(input string name, input logic ok,
                         input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Consumer ready: always, random, or random with a forced stall on the last word.
    initial begin
        int hold;
        hold = 0;
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.rd_ready = 1'b1;
                1: bus.rd_ready = ($urandom_range(2, 0) != 0);
                default: begin
                    if (bus.rd_valid && bus.rd_last) begin
                        bus.rd_ready = (hold >= 3);
                        hold++;
                    end else begin
                        hold = 0;
                        bus.rd_ready = ($urandom_range(1, 0) != 0);
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (capture_done) done_cnt++;
            if (prev_stall) begin
                check("stall_hold_valid", bus.rd_valid == 1'b1, W'(bus.rd_valid), W'(1));
                check("stall_hold_data", bus.rd_data == prev_data, bus.rd_data, prev_data);
                check("stall_hold_last", bus.rd_last == prev_last, W'(bus.rd_last), W'(prev_last));
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b0, bus.rd_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", bus.rd_data == e.dat, bus.rd_data, e.dat);
                    check("rd_last", bus.rd_last == e.last, W'(bus.rd_last), W'(e.last));
                end
            end
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_data  = bus.rd_data;
            prev_last  = bus.rd_last;
        end
    end

    task automatic drive_random_data();
        bus.data_in_i = {$urandom, $urandom};
        bus.data_in_q = {$urandom, $urandom};
    endtask

    // One full record: arm, feed stream, check capture/readout timing, wait for the last word.
    // Expected record = every (d+1)-th valid word after arm, first L of them.
    task automatic run_record(input int dcm, input int len, input int vmode, input bit arm_mid);
        int L, stored, vcount, cyc, done0;
        bit v, got;
        L = (len == 0 || len > DEPTH) ? DEPTH : len;
        stored = 0; vcount = 0; cyc = 0; done0 = done_cnt;
        arm = 1'b1;
        decim = dcm[7:0];
        capture_len = len[AW:0];
        bus.data_valid = 1'b0;
        drive_random_data();
        @(posedge clk); #1;
        arm = 1'b0;
        decim = 8'($urandom);
        capture_len = (AW+1)'($urandom);
        while (stored < L && cyc < 5000) begin
            case (vmode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(1, 0) != 0);
            endcase
            bus.data_valid = v;
            drive_random_data();
            arm = arm_mid && (cyc == 2);
            if (v) begin
                if (vcount % (dcm + 1) == 0) begin
                    exp_q.push_back('{dat: {bus.data_in_q, bus.data_in_i}, last: (stored == L - 1)});
                    stored++;
                end
                vcount++;
            end
            if (cyc == 0) begin
                @(negedge clk);
                check("busy_after_arm", busy == 1'b1, W'(busy), W'(1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        arm = 1'b0;
        check("capture_budget", stored == L, W'(stored), W'(L));
        bus.data_valid = 1'b1;
        drive_random_data();
        @(negedge clk);
        check("capture_done_pulse", capture_done == 1'b1, W'(capture_done), W'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_valid_lat1", {bus.rd_valid, capture_done} == 2'b00, W'({bus.rd_valid, capture_done}), '0);
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        @(negedge clk);
        check("rd_valid_lat2", bus.rd_valid == 1'b1, W'(bus.rd_valid), W'(1));
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (bus.rd_valid && bus.rd_ready && bus.rd_last) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("last_handshake_seen", got, W'(got), W'(1));
        @(posedge clk); #1;
        check("busy_after_record", busy == 1'b0, W'(busy), '0);
        check("scoreboard_drained", exp_q.size() == 0, W'(exp_q.size()), '0);
        check("capture_done_count", done_cnt - done0 == 1, W'(done_cnt - done0), W'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        arm = 1'b0;
        decim = '0;
        capture_len = '0;
        bus.data_valid = 1'b0;
        bus.data_in_i = '0;
        bus.data_in_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {busy, capture_done, bus.rd_valid, bus.rd_last} == 4'b0 && bus.rd_data == '0,
              {bus.rd_data[W-5:0], busy, capture_done, bus.rd_valid, bus.rd_last}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_record(0, 4, 0, 1'b0);
        run_record(2, 3, 0, 1'b0);
        run_record(0, 8, 1, 1'b0);
        run_record(1, 6, 0, 1'b1);

        ready_mode = 2;
        run_record(0, 16, 0, 1'b0);
        run_record(0, 5, 2, 1'b0);
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            run_record(int'($urandom_range(3, 0)), int'($urandom_range(20, 0)),
                       int'($urandom_range(2, 0)), 1'b0);
        end

        ready_mode = 0;
        run_record(0, 0, 0, 1'b0);
        run_record(0, 20, 0, 1'b0);
        run_record(255, 2, 0, 1'b0);

        // Reset in the middle of a capture, then a fresh record from address 0.
        arm = 1'b1;
        decim = 8'd0;
        capture_len = (AW+1)'(10);
        @(posedge clk); #1;
        arm = 1'b0;
        repeat (3) begin
            bus.data_valid = 1'b1;
            drive_random_data();
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        bus.data_valid = 1'b0;
        @(negedge clk);
        check("midcap_reset_outputs",
              {busy, capture_done, bus.rd_valid, bus.rd_last} == 4'b0 && bus.rd_data == '0,
              {bus.rd_data[W-5:0], busy, capture_done, bus.rd_valid, bus.rd_last}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        run_record(0, 5, 0, 1'b0);
        ready_mode = 2;
        run_record(1, 7, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
